// File: rtl/dac_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dac_serial_ctrl
// Purpose  : Serial write engine for DAC7611-class 3-wire DACs (CLK/SDI/LD/CLR).
//            Accepts one word per channel over valid/ready, shifts all channels
//            in lockstep on a shared serial clock (one SDI line per channel),
//            then pulses LD low to latch. A CLR pulse can be requested at any
//            time; it runs as soon as the engine is idle.
// Ports    : clk          system clock (posedge)
//            rst_n        asynchronous active-low reset
//            i_wr_valid   i_wr_data is valid
//            o_wr_ready   engine idle and able to accept a word
//            i_wr_data    channel c = i_wr_data[c*DATA_W +: DATA_W]
//            i_clr_req    single-cycle request for a CLR pulse
//            o_dac_clk    DAC serial clock, idles high
//            o_dac_sdi    serial data, one bit per channel
//            o_dac_ld     load strobe, active low
//            o_dac_clr    clear, active low
//            o_busy       high in SHIFT, LOAD or CLEAR
//            o_done       one-cycle pulse when a frame's LD pulse ends
// Revision : 1.0 - initial release
// ============================================================================
module dac_serial_ctrl #(
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 1,
    parameter int HALF_DIV   = 1,
    parameter int LD_CYCLES  = 1,
    parameter int CLR_CYCLES = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
    input  logic                     i_clr_req,
    output logic                     o_dac_clk,
    output logic [NUM_CH-1:0]        o_dac_sdi,
    output logic                     o_dac_ld,
    output logic                     o_dac_clr,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int TOT_W    = NUM_CH * DATA_W;
    localparam int BIT_W    = $clog2(DATA_W + 1);
    localparam int DIV_W    = $clog2(HALF_DIV + 1);
    localparam int HOLD_MAX = (LD_CYCLES > CLR_CYCLES) ? LD_CYCLES : CLR_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [BIT_W-1:0]  c_BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  c_DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [HOLD_W-1:0] c_LD_LAST  = HOLD_W'(LD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_CLR_LAST = HOLD_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic [BIT_W-1:0]    r_bit, w_bit;
    logic [DIV_W-1:0]    r_div, w_div;
    logic [HOLD_W-1:0]   r_hold, w_hold;
    logic [TOT_W-1:0]    r_shreg, w_shreg;
    logic                r_clr_pend, w_clr_pend;
    logic                r_dac_clk, w_dac_clk;
    logic [NUM_CH-1:0]   r_dac_sdi, w_dac_sdi;
    logic                r_dac_ld, w_dac_ld;
    logic                r_dac_clr, w_dac_clr;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_wr_ready, w_wr_ready;

    // Per-channel bit selection. The shift register holds the bits not yet
    // presented; the bit on SDI lives in r_dac_sdi.
    logic [NUM_CH-1:0]   w_first_sdi;   // first bit of the incoming word
    logic [TOT_W-1:0]    w_cap_shreg;   // incoming word with first bit removed
    logic [NUM_CH-1:0]   w_next_sdi;    // next bit from the shift register
    logic [TOT_W-1:0]    w_step_shreg;  // shift register after taking next bit

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        if (MSB_FIRST != 0) begin : g_msb
            assign w_first_sdi[c]                    = i_wr_data[c*DATA_W + DATA_W - 1];
            assign w_cap_shreg[c*DATA_W +: DATA_W]   = i_wr_data[c*DATA_W +: DATA_W] << 1;
            assign w_next_sdi[c]                     = r_shreg[c*DATA_W + DATA_W - 1];
            assign w_step_shreg[c*DATA_W +: DATA_W]  = r_shreg[c*DATA_W +: DATA_W] << 1;
        end else begin : g_lsb
            assign w_first_sdi[c]                    = i_wr_data[c*DATA_W];
            assign w_cap_shreg[c*DATA_W +: DATA_W]   = i_wr_data[c*DATA_W +: DATA_W] >> 1;
            assign w_next_sdi[c]                     = r_shreg[c*DATA_W];
            assign w_step_shreg[c*DATA_W +: DATA_W]  = r_shreg[c*DATA_W +: DATA_W] >> 1;
        end
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here are what the pins show in the following cycle.
    always_comb begin
        w_state    = r_state;
        w_bit      = r_bit;
        w_div      = r_div;
        w_hold     = r_hold;
        w_shreg    = r_shreg;
        w_clr_pend = r_clr_pend;
        w_dac_clk  = r_dac_clk;
        w_dac_sdi  = r_dac_sdi;
        w_dac_ld   = 1'b1;
        w_dac_clr  = 1'b1;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_dac_clk = 1'b1;
                w_dac_sdi = '0;
                if (r_clr_pend || i_clr_req) begin
                    // A clear wins over a word offered in the same cycle.
                    w_state    = S_CLEAR;
                    w_clr_pend = 1'b0;
                    w_dac_clr  = 1'b0;
                end else if (i_wr_valid && r_wr_ready) begin
                    w_state   = S_SHIFT;
                    w_shreg   = w_cap_shreg;
                    w_dac_sdi = w_first_sdi;
                    w_dac_clk = 1'b0;
                end
            end

            S_SHIFT: begin
                if (i_clr_req) begin
                    w_clr_pend = 1'b1;
                end
                if (r_div == c_DIV_LAST) begin
                    w_div = '0;
                    if (!r_dac_clk) begin
                        // End of low phase: rising edge, DAC samples here.
                        w_dac_clk = 1'b1;
                    end else if (r_bit == c_BIT_LAST) begin
                        w_state   = S_LOAD;
                        w_dac_ld  = 1'b0;
                        w_dac_clk = 1'b1;
                        w_dac_sdi = '0;
                    end else begin
                        // Next bit goes out together with the falling edge.
                        w_bit     = r_bit + 1'b1;
                        w_dac_clk = 1'b0;
                        w_dac_sdi = w_next_sdi;
                        w_shreg   = w_step_shreg;
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end

            S_LOAD: begin
                if (i_clr_req) begin
                    w_clr_pend = 1'b1;
                end
                if (r_hold == c_LD_LAST) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_hold   = r_hold + 1'b1;
                    w_dac_ld = 1'b0;
                end
            end

            S_CLEAR: begin
                // Requests arriving here are already covered by this pulse.
                if (r_hold == c_CLR_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_hold    = r_hold + 1'b1;
                    w_dac_clr = 1'b0;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // All counters restart on every state entry (including IDLE->SHIFT
        // when frames run back to back).
        if (w_state != r_state) begin
            w_bit  = '0;
            w_div  = '0;
            w_hold = '0;
        end

        w_busy = (w_state != S_IDLE);
        // A pending clear must run before the next word, so ready stays low
        // on the done cycle of a frame that had a clear queued behind it.
        w_wr_ready = (w_state == S_IDLE) && !w_clr_pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit      <= '0;
            r_div      <= '0;
            r_hold     <= '0;
            r_shreg    <= '0;
            r_clr_pend <= 1'b0;
            r_dac_clk  <= 1'b1;
            r_dac_sdi  <= '0;
            r_dac_ld   <= 1'b1;
            r_dac_clr  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_bit      <= w_bit;
            r_div      <= w_div;
            r_hold     <= w_hold;
            r_shreg    <= w_shreg;
            r_clr_pend <= w_clr_pend;
            r_dac_clk  <= w_dac_clk;
            r_dac_sdi  <= w_dac_sdi;
            r_dac_ld   <= w_dac_ld;
            r_dac_clr  <= w_dac_clr;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_wr_ready <= w_wr_ready;
        end
    end

    assign o_wr_ready = r_wr_ready;
    assign o_dac_clk  = r_dac_clk;
    assign o_dac_sdi  = r_dac_sdi;
    assign o_dac_ld   = r_dac_ld;
    assign o_dac_clr  = r_dac_clr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule
`default_nettype wire
